// File: rtl/arf086b128e1r1w0cbbehsaa4acw_rd_pkg.sv
// Shared types and sizes for the 1R1W latch register file read port.
package arf086b128e1r1w0cbbehsaa4acw_rd_pkg;

  localparam int DWIDTH = 86;
  localparam int DEPTH  = 128;
  localparam int AWIDTH = $clog2(DEPTH);

  // One queued read response: out-of-range flag plus the merged read data.
  typedef struct packed {
    logic              err;
    logic [DWIDTH-1:0] data;
  } rd_rsp_t;

endpackage

// File: rtl/arf086b128e1r1w0cbbehsaa4acw_rd_fifo.sv
// Small flop-based response FIFO for the register file read port.
// No combinational pass-through: a push is visible at the head one cycle later.
// While empty the head output keeps the last popped entry so the data bus never goes X.
module arf086b128e1r1w0cbbehsaa4acw_rd_fifo
  import arf086b128e1r1w0cbbehsaa4acw_rd_pkg::*;
#(
  parameter int FDEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  rd_rsp_t push_data_i,
  input  logic    pop_i,
  output logic    vld_o,
  output logic    full_o,
  output rd_rsp_t head_o
);

  localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int CW = $clog2(FDEPTH + 1);

  rd_rsp_t       mem_q [FDEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  rd_rsp_t       hold_q, hold_d;
  logic          push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next-state for pointers, occupancy and the idle hold value.
  always_comb begin
    vld_o    = (count_q != '0);
    full_o   = (count_q == CW'(FDEPTH));
    pop      = pop_i & vld_o;
    // A full FIFO only takes a new entry when the head leaves in the same cycle.
    push     = push_i & (~full_o | pop);
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    hold_d   = pop ? mem_q[rd_ptr_q] : hold_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    head_o   = vld_o ? mem_q[rd_ptr_q] : hold_q;
  end

  // Storage, pointers and occupancy; reset clears everything so no stale entry survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FDEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: rtl/arf086b128e1r1w0cbbehsaa4acw_rd_port.sv
// Read-side controller of the 1R1W latch register file.
// Accepts read requests, drives the array read mux, forwards a same-cycle write to the
// same address (the phase-B latch write lands after the read mux samples), and returns
// responses in order through a small FIFO with valid/ready back-pressure.
module arf086b128e1r1w0cbbehsaa4acw_rd_port
  import arf086b128e1r1w0cbbehsaa4acw_rd_pkg::*;
#(
  parameter int DEPTH     = arf086b128e1r1w0cbbehsaa4acw_rd_pkg::DEPTH,
  parameter int AWIDTH    = $clog2(DEPTH),
  parameter int FDEPTH    = 2,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic              rd_rdy,
  output logic [AWIDTH-1:0] arr_rd_addr,
  output logic              arr_rd_en,
  input  logic [DWIDTH-1:0] arr_rd_data,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              rsp_vld,
  output logic [DWIDTH-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              rsp_rdy
);

  logic    addr_err, wr_hit, accept, pop;
  logic    fifo_vld, fifo_full;
  rd_rsp_t merged, head;

  // Handshake and merge of array data with a snooped same-cycle write.
  always_comb begin
    pop         = fifo_vld & rsp_rdy;
    // A pop in this cycle frees a slot, so a full FIFO can still accept.
    rd_rdy      = ~rst & (~fifo_full | pop);
    accept      = rd_req & rd_rdy;
    arr_rd_en   = accept;
    arr_rd_addr = rd_addr;
    addr_err    = (int'(rd_addr) >= DEPTH);
    // Out-of-range write addresses never forward.
    wr_hit      = BYPASS_EN && wr_en && (wr_addr == rd_addr) && (int'(wr_addr) < DEPTH);
    merged.err  = addr_err;
    merged.data = addr_err ? '0 : (wr_hit ? wr_data : arr_rd_data);
    rsp_vld     = fifo_vld;
    rsp_data    = head.data;
    rsp_err     = head.err;
  end

  arf086b128e1r1w0cbbehsaa4acw_rd_fifo #(
    .FDEPTH(FDEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (accept),
    .push_data_i(merged),
    .pop_i      (pop),
    .vld_o      (fifo_vld),
    .full_o     (fifo_full),
    .head_o     (head)
  );

  // An accepted request must always find room in the FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) accept |-> (~fifo_full | pop));

endmodule

// File: tb/tb_arf086b128e1r1w0cbbehsaa4acw_rd_port.sv
// Scoreboard bench: two instances (default, and DEPTH=100 without forwarding) share stimulus.
module tb_arf086b128e1r1w0cbbehsaa4acw_rd_port;
  import arf086b128e1r1w0cbbehsaa4acw_rd_pkg::*;

  localparam int DW = DWIDTH;
  localparam int AW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rd_req, wr_en, rsp_rdy;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_data;

  logic          rd_rdy_a, arr_en_a, vld_a, err_a;
  logic [AW-1:0] arr_addr_a;
  logic [DW-1:0] data_a, arr_data_a;
  logic          rd_rdy_b, arr_en_b, vld_b, err_b;
  logic [AW-1:0] arr_addr_b;
  logic [DW-1:0] data_b, arr_data_b;

  logic [DW-1:0] mem [128];

  // Latch array stub: writes land after the edge, reset clears it.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign arr_data_a = mem[arr_addr_a];
  assign arr_data_b = mem[arr_addr_b];

  arf086b128e1r1w0cbbehsaa4acw_rd_port u_dut_a (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy_a),
    .arr_rd_addr(arr_addr_a), .arr_rd_en(arr_en_a), .arr_rd_data(arr_data_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsp_vld(vld_a), .rsp_data(data_a), .rsp_err(err_a), .rsp_rdy(rsp_rdy)
  );

  arf086b128e1r1w0cbbehsaa4acw_rd_port #(.DEPTH(100), .BYPASS_EN(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy_b),
    .arr_rd_addr(arr_addr_b), .arr_rd_en(arr_en_b), .arr_rd_data(arr_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsp_vld(vld_b), .rsp_data(data_b), .rsp_err(err_b), .rsp_rdy(rsp_rdy)
  );

  int errors = 0;
  int checks = 0;

  rd_rsp_t cur_a, cur_b, held_a, held_b, hand_a, hand_b;
  rd_rsp_t q_a[$];
  rd_rsp_t q_b[$];
  int      cnt = 0;
  bit      use_hand;
  bit      st_a = 1'b0, st_b = 1'b0;
  bit      exp_rdy, acc, pop_m;

  assign cur_a = {err_a, data_a};
  assign cur_b = {err_b, data_b};

  task automatic chk_b(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_a(string nm, logic [AW-1:0] act, logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_r(string nm, rd_rsp_t act, rd_rsp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got err=%b data=%h expected err=%b data=%h",
               nm, act.err, act.data, exp.err, exp.data);
    end
  endtask

  task automatic chk_i(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic rd_rsp_t mk(logic e, logic [DW-1:0] d);
    rd_rsp_t r;
    r.err  = e;
    r.data = d;
    return r;
  endfunction

  // Reference behaviour of the merge for a port of the given depth/forwarding option.
  function automatic rd_rsp_t model(int depth, bit byp);
    rd_rsp_t r;
    r.err = (int'(rd_addr) >= depth);
    if (r.err) r.data = '0;
    else if (byp && wr_en && (wr_addr == rd_addr) && (int'(wr_addr) < depth)) r.data = wr_data;
    else r.data = mem[rd_addr];
    return r;
  endfunction

  // Request side: check handshake against occupancy model, push expected responses.
  always @(negedge clk) begin
    if (rst) begin
      chk_b("rst_rdy_a", rd_rdy_a, 1'b0);
      chk_b("rst_rdy_b", rd_rdy_b, 1'b0);
      chk_b("rst_arr_en_a", arr_en_a, 1'b0);
      chk_b("rst_arr_en_b", arr_en_b, 1'b0);
      q_a.delete();
      q_b.delete();
      cnt = 0;
    end else begin
      exp_rdy = (cnt < 2) || ((cnt > 0) && rsp_rdy);
      acc     = rd_req && exp_rdy;
      pop_m   = (cnt > 0) && rsp_rdy;
      chk_b("rd_rdy_a", rd_rdy_a, exp_rdy);
      chk_b("rd_rdy_b", rd_rdy_b, exp_rdy);
      chk_b("rsp_vld_a", vld_a, cnt > 0);
      chk_b("rsp_vld_b", vld_b, cnt > 0);
      chk_b("arr_en_a", arr_en_a, acc);
      chk_b("arr_en_b", arr_en_b, acc);
      chk_a("arr_addr_a", arr_addr_a, rd_addr);
      if (acc) begin
        if (use_hand) begin
          q_a.push_back(hand_a);
          q_b.push_back(hand_b);
        end else begin
          q_a.push_back(model(128, 1'b1));
          q_b.push_back(model(100, 1'b0));
        end
      end
      cnt = cnt + (acc ? 1 : 0) - (pop_m ? 1 : 0);
    end
  end

  // Response side: pop and compare on every transfer, and check stability under stall.
  always @(negedge clk) begin
    if (rst) begin
      st_a = 1'b0;
      st_b = 1'b0;
    end else begin
      if (st_a) chk_r("stall_hold_a", cur_a, held_a);
      if (st_b) chk_r("stall_hold_b", cur_b, held_b);
      if (vld_a && rsp_rdy) begin
        if (q_a.size() == 0) chk_i("extra_rsp_a_queue", 0, 1);
        else chk_r("rsp_a", cur_a, q_a.pop_front());
      end
      if (vld_b && rsp_rdy) begin
        if (q_b.size() == 0) chk_i("extra_rsp_b_queue", 0, 1);
        else chk_r("rsp_b", cur_b, q_b.pop_front());
      end
      st_a   = vld_a && !rsp_rdy;
      st_b   = vld_b && !rsp_rdy;
      held_a = cur_a;
      held_b = cur_b;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    cyc();
    wr_en   = 1'b0;
  endtask

  task automatic req(input logic [AW-1:0] a, input rd_rsp_t ea, input rd_rsp_t eb);
    hand_a  = ea;
    hand_b  = eb;
    rd_req  = 1'b1;
    rd_addr = a;
    cyc();
    rd_req  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsp_rdy = 1'b1; use_hand = 1'b1; hand_a = '0; hand_b = '0;
    repeat (2) cyc();
    rst = 1'b0;
    @(negedge clk);
    chk_r("reset_out_a", cur_a, '0);
    chk_r("reset_out_b", cur_b, '0);

    wr(5, 'h15); wr(1, 'h101); wr(2, 'h202); wr(3, 'h303);
    wr(120, 'h777); wr(99, 'h99); wr(100, 'h100);

    // Plain read, latency one.
    req(5, mk(1'b0, 'h15), mk(1'b0, 'h15));
    // Same-cycle write forwarding vs. no forwarding, then a write to another address.
    wr_en = 1'b1; wr_addr = 9; wr_data = 'h3FF;
    req(9, mk(1'b0, 'h3FF), mk(1'b0, 'h0));
    wr_addr = 10; wr_data = 'h2AA; wr_en = 1'b1;
    req(9, mk(1'b0, 'h3FF), mk(1'b0, 'h3FF));
    wr_en = 1'b0;
    repeat (2) cyc();

    // Back-pressure: two fill the FIFO, third waits until a pop in the same cycle.
    rsp_rdy = 1'b0;
    rd_req = 1'b1; rd_addr = 1; hand_a = mk(1'b0, 'h101); hand_b = mk(1'b0, 'h101); cyc();
    rd_addr = 2; hand_a = mk(1'b0, 'h202); hand_b = mk(1'b0, 'h202); cyc();
    rd_addr = 3; hand_a = mk(1'b0, 'h303); hand_b = mk(1'b0, 'h303);
    @(negedge clk);
    chk_b("full_rdy_a", rd_rdy_a, 1'b0);
    chk_b("full_rdy_b", rd_rdy_b, 1'b0);
    cyc(); cyc();
    rsp_rdy = 1'b1;
    @(negedge clk);
    chk_b("pop_frees_rdy_a", rd_rdy_a, 1'b1);
    cyc();
    rd_req = 1'b0;
    repeat (3) cyc();

    // Range boundary: 120 and 100 are out of range only for the DEPTH=100 instance.
    req(120, mk(1'b0, 'h777), mk(1'b1, 'h0));
    req(99, mk(1'b0, 'h99), mk(1'b0, 'h99));
    req(100, mk(1'b0, 'h100), mk(1'b1, 'h0));
    wr_en = 1'b1; wr_addr = 110; wr_data = 'hABC;
    req(110, mk(1'b0, 'hABC), mk(1'b1, 'h0));
    wr_en = 1'b0;
    repeat (2) cyc();

    // Reset with responses pending and a request held high.
    rsp_rdy = 1'b0;
    req(5, mk(1'b0, 'h15), mk(1'b0, 'h15));
    req(9, mk(1'b0, 'h3FF), mk(1'b0, 'h3FF));
    rd_req = 1'b1; rd_addr = 9; rst = 1'b1;
    @(negedge clk);
    chk_b("rst_pending_rdy_a", rd_rdy_a, 1'b0);
    cyc();
    rst = 1'b0; rd_req = 1'b0; rsp_rdy = 1'b1;
    @(negedge clk);
    chk_b("post_rst_vld_a", vld_a, 1'b0);
    chk_r("post_rst_out_a", cur_a, '0);
    chk_r("post_rst_out_b", cur_b, '0);
    repeat (3) cyc();

    // Random traffic checked against the reference model.
    use_hand = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      rd_req  = ($urandom_range(3, 0) != 0);
      rd_addr = AW'($urandom_range(127, 0));
      wr_en   = $urandom_range(1, 0) == 1;
      wr_addr = ($urandom_range(1, 0) == 1) ? rd_addr : AW'($urandom_range(127, 0));
      wr_data = DW'({$urandom(), $urandom(), $urandom()});
      rsp_rdy = ($urandom_range(9, 0) < 6);
      cyc();
    end
    rd_req = 1'b0; wr_en = 1'b0; rsp_rdy = 1'b1;
    repeat (5) cyc();
    @(negedge clk);
    chk_i("drain_queue_a", q_a.size(), 0);
    chk_i("drain_queue_b", q_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
